mixer: RTL and testbench

//  Sums the four per-voice sample streams (pipe1..pipe4) into one mono sample
//  for the synth output path, sitting between the voice pipelines and the DAC/IO stage.

---
 rtl/mixer_if.sv | 24 ++
 rtl/mixer.sv | 79 +++++++
 tb/tb_mixer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mixer_if.sv
// Voice-mixer bus: four signed voice samples plus valid in, mixed sample, valid and clip out.
// The master side drives the voices; the slave side is the mixer.
interface mixer_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] pipe1;
  logic [DATA_W-1:0] pipe2;
  logic [DATA_W-1:0] pipe3;
  logic [DATA_W-1:0] pipe4;
  logic              in_valid;
  logic [DATA_W-1:0] mixer_output;
  logic              out_valid;
  logic              clip;

  modport master (
    output pipe1, pipe2, pipe3, pipe4, in_valid,
    input  mixer_output, out_valid, clip
  );

  modport slave (
    input  pipe1, pipe2, pipe3, pipe4, in_valid,
    output mixer_output, out_valid, clip
  );
endinterface

// File: rtl/mixer.sv
// Four-voice mono mixer: sign-extended sum, arithmetic right shift, registered output.
// Optional MIXER_SAT_EN clamps the narrowed result and reports it on clip; otherwise it wraps.
module mixer #(
  parameter int DATA_W = 24,
  parameter int SHIFT  = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  mixer_if.slave bus
);

  localparam int SUM_W = DATA_W + 2;

  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  w_scaled;
  logic        [DATA_W-1:0] w_narrow;
  logic                     w_clip;

  logic [DATA_W-1:0] r_mixer_output;
  logic              r_out_valid;

  // Two guard bits make the four-way sum exact for any inputs.
  assign w_sum = $signed({{2{bus.pipe1[DATA_W-1]}}, bus.pipe1})
               + $signed({{2{bus.pipe2[DATA_W-1]}}, bus.pipe2})
               + $signed({{2{bus.pipe3[DATA_W-1]}}, bus.pipe3})
               + $signed({{2{bus.pipe4[DATA_W-1]}}, bus.pipe4});

  assign w_scaled = w_sum >>> SHIFT;

`ifdef MIXER_SAT_EN
  localparam logic signed [SUM_W-1:0] MAX_VAL = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_VAL = {3'b111, {(DATA_W-1){1'b0}}};

  logic r_clip;

  always_comb begin
    w_narrow = w_scaled[DATA_W-1:0];
    w_clip   = 1'b0;
    if (w_scaled > MAX_VAL) begin
      w_narrow = {1'b0, {(DATA_W-1){1'b1}}};
      w_clip   = 1'b1;
    end else if (w_scaled < MIN_VAL) begin
      w_narrow = {1'b1, {(DATA_W-1){1'b0}}};
      w_clip   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clip <= 1'b0;
    end else if (bus.in_valid) begin
      r_clip <= w_clip;
    end
  end

  assign bus.clip = r_clip;
`else
  assign w_narrow = DATA_W'(w_scaled);
  assign w_clip   = 1'b0;
  assign bus.clip = w_clip;
`endif

  // Output only moves on in_valid, so unknown voices between samples are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mixer_output <= '0;
      r_out_valid    <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_mixer_output <= w_narrow;
      end
    end
  end

  assign bus.mixer_output = r_mixer_output;
  assign bus.out_valid    = r_out_valid;

endmodule

// File: tb/tb_mixer.sv
// Self-checking bench for mixer: directed vector table, hold/reset sequences,
// and randomized traffic against an arithmetic reference model.
module tb_mixer;

  localparam int DATA_W = 24;
  localparam int SHIFT  = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mixer_if #(.DATA_W(DATA_W)) bus ();

  mixer #(.DATA_W(DATA_W), .SHIFT(SHIFT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [23:0] p1;
    logic [23:0] p2;
    logic [23:0] p3;
    logic [23:0] p4;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[10];

  logic [23:0] exp_out;
  logic        exp_valid;
  logic        exp_clip;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Mean of four signed voices, floor-rounded, then wrapped or clamped to DATA_W.
  function automatic logic [23:0] model(input logic [23:0] a, input logic [23:0] b,
                                        input logic [23:0] c, input logic [23:0] d,
                                        output logic clipped);
    longint s, q, div, lo, hi;
    logic [63:0] qb;
    s = longint'($signed(a)) + longint'($signed(b)) + longint'($signed(c)) + longint'($signed(d));
    div = longint'(1) << SHIFT;
    q = s / div;
    if ((s % div) != 0 && s < 0) q = q - 1;
    hi = (longint'(1) << (DATA_W - 1)) - 1;
    lo = -(longint'(1) << (DATA_W - 1));
    clipped = 1'b0;
`ifdef MIXER_SAT_EN
    if (q > hi) begin q = hi; clipped = 1'b1; end
    if (q < lo) begin q = lo; clipped = 1'b1; end
`endif
    qb = q;
    return qb[23:0];
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_out"},   {8'h0, bus.mixer_output}, {8'h0, exp_out});
    chk({tag, "_valid"}, {31'h0, bus.out_valid},   {31'h0, exp_valid});
    chk({tag, "_clip"},  {31'h0, bus.clip},        {31'h0, exp_clip});
  endtask

  task automatic drive(input logic [23:0] a, input logic [23:0] b,
                       input logic [23:0] c, input logic [23:0] d, input logic v);
    bus.pipe1 = a; bus.pipe2 = b; bus.pipe3 = c; bus.pipe4 = d; bus.in_valid = v;
  endtask

  initial begin
    logic        clp;
    logic [23:0] r[4];
    logic        v;
    checks = 0;
    failures = 0;

    vecs[0] = '{"all_3fffff", 24'h3FFFFF, 24'h3FFFFF, 24'h3FFFFF, 24'h3FFFFF, 24'h3FFFFF};
    vecs[1] = '{"mixed_ffff", 24'h00FFFF, 24'h000FFF, 24'h000FFF, 24'h000FFF, 24'h004BFF};
    vecs[2] = '{"floor_3120", 24'h000003, 24'h000001, 24'h000002, 24'h000000, 24'h000001};
    vecs[3] = '{"all_f",      24'h00000F, 24'h00000F, 24'h00000F, 24'h00000F, 24'h00000F};
    vecs[4] = '{"all_m1",     24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    vecs[5] = '{"all_min",    24'h800000, 24'h800000, 24'h800000, 24'h800000, 24'h800000};
    vecs[6] = '{"all_max",    24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF};
    vecs[7] = '{"one_pos",    24'h000001, 24'h000000, 24'h000000, 24'h000000, 24'h000000};
    vecs[8] = '{"one_neg",    24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000, 24'hFFFFFF};
    vecs[9] = '{"neg4",       24'hFFFFFC, 24'h000000, 24'h000000, 24'h000000, 24'hFFFFFF};

    rst_n = 1'b0;
    drive(24'h123456, 24'h654321, 24'h0, 24'h0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    exp_out = '0; exp_valid = 1'b0; exp_clip = 1'b0;
    check_outputs("reset");

    // Back-to-back vectors: every cycle must produce a valid output.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].p1, vecs[i].p2, vecs[i].p3, vecs[i].p4, 1'b1);
      @(posedge clk);
      #1;
      exp_out = vecs[i].exp; exp_valid = 1'b1;
      exp_clip = 1'b0;
      void'(model(vecs[i].p1, vecs[i].p2, vecs[i].p3, vecs[i].p4, exp_clip));
      check_outputs(vecs[i].name);
      @(negedge clk);
    end

    // Hold: three idle cycles with garbage voices.
    drive(24'h000003, 24'h000001, 24'h000002, 24'h000000, 1'b1);
    @(posedge clk); #1;
    exp_out = 24'h000001; exp_valid = 1'b1; exp_clip = 1'b0;
    check_outputs("hold_load");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(24'h7FFFFF, 24'hxxxxxx, 24'h555555, 24'hxxxxxx, 1'b0);
      @(posedge clk); #1;
      exp_valid = 1'b0;
      check_outputs("hold_idle");
    end

    // Asynchronous reset while streaming.
    @(negedge clk);
    drive(24'h3FFFFF, 24'h3FFFFF, 24'h3FFFFF, 24'h3FFFFF, 1'b1);
    @(posedge clk); #1;
    exp_out = 24'h3FFFFF; exp_valid = 1'b1; exp_clip = 1'b0;
    check_outputs("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    exp_out = '0; exp_valid = 1'b0; exp_clip = 1'b0;
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(24'h00FFFF, 24'h000FFF, 24'h000FFF, 24'h000FFF, 1'b1);
    @(posedge clk); #1;
    exp_out = 24'h004BFF; exp_valid = 1'b1;
    check_outputs("first_after_rst");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0: r[k] = 24'h7FFFFF;
          1: r[k] = 24'h800000;
          default: r[k] = 24'($urandom);
        endcase
      end
      v = 1'($urandom_range(0, 1));
      drive(r[0], r[1], r[2], r[3], v);
      @(posedge clk);
      if (v) begin
        exp_out = model(r[0], r[1], r[2], r[3], clp);
        exp_clip = clp;
      end
      exp_valid = v;
      #1;
      check_outputs("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
